// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
// fetch_stage: IF stage plus IF/ID register with static BTFN prediction.
// Variable-latency imem handshake, redirect squash and a stall hold buffer.
module fetch_stage #(
  parameter int unsigned WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] RESET_PC = '0,
  parameter logic [WORD_SIZE-1:0] NOP_INSTR = 32'h00000013
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 StallF,
  input  logic                 StallD,
  input  logic                 FlushD,
  input  logic                 RedirectE,
  input  logic [WORD_SIZE-1:0] RedirectPCE,
  output logic                 ImemReq,
  output logic [WORD_SIZE-1:0] ImemAddr,
  input  logic                 ImemValid,
  input  logic [WORD_SIZE-1:0] ImemData,
  output logic [WORD_SIZE-1:0] InstrD,
  output logic [WORD_SIZE-1:0] PCD,
  output logic [WORD_SIZE-1:0] PCPlus4D,
  output logic                 TakingBranch,
  output logic                 FetchBusy
);

  localparam int unsigned W = WORD_SIZE;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   pcf_q, pcf_d;
  logic [W-1:0]   hold_q, hold_d;
  logic           squash_q, squash_d;

  logic           stall;
  logic           deliver;
  logic           pred;
  logic [W-1:0]   word;
  logic [W-1:0]   bimm;
  logic [W-1:0]   pc_plus4;

  assign stall    = StallF | StallD;
  assign word     = (state_q == S_HOLD) ? hold_q : ImemData;
  assign pred     = (word[6:0] == OP_BRANCH) & word[31];
  assign bimm     = {{(W-12){word[31]}}, word[7], word[30:25],
                     word[11:8], 1'b0};
  assign pc_plus4 = pcf_q + W'(4);

  assign ImemReq   = (state_q == S_WAIT);
  assign ImemAddr  = pcf_q;
  assign FetchBusy = ~deliver;

  // Fetch FSM: request/response tracking, hold buffer, PC selection
  always_comb begin
    state_d  = state_q;
    pcf_d    = pcf_q;
    hold_d   = hold_q;
    squash_d = squash_q;
    deliver  = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_WAIT;
      S_WAIT: begin
        if (ImemValid) begin
          if (squash_q) begin
            squash_d = 1'b0;
          end else if (!stall) begin
            deliver = 1'b1;
          end else begin
            hold_d  = ImemData;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
          deliver = 1'b1;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (RedirectE) begin
      deliver  = 1'b0;
      pcf_d    = RedirectPCE;
      state_d  = S_WAIT;
      squash_d = (state_q == S_WAIT) & ~ImemValid;
    end else if (deliver) begin
      pcf_d = pred ? (pcf_q + bimm) : pc_plus4;
    end
  end

  // Fetch state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pcf_q    <= RESET_PC;
      hold_q   <= '0;
      squash_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pcf_q    <= pcf_d;
      hold_q   <= hold_d;
      squash_q <= squash_d;
    end
  end

  // IF/ID register: flush > hold > deliver > bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      InstrD       <= NOP_INSTR;
      PCD          <= '0;
      PCPlus4D     <= '0;
      TakingBranch <= 1'b0;
    end else if (FlushD) begin
      InstrD       <= NOP_INSTR;
      PCD          <= '0;
      PCPlus4D     <= '0;
      TakingBranch <= 1'b0;
    end else if (StallD) begin
      InstrD       <= InstrD;
      PCD          <= PCD;
      PCPlus4D     <= PCPlus4D;
      TakingBranch <= TakingBranch;
    end else if (deliver) begin
      InstrD       <= word;
      PCD          <= pcf_q;
      PCPlus4D     <= pc_plus4;
      TakingBranch <= pred;
    end else begin
      InstrD       <= NOP_INSTR;
      PCD          <= '0;
      PCPlus4D     <= '0;
      TakingBranch <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
// tb_fetch_stage: random stalls/redirects/latency against a program-flow
// model; expected IF/ID contents are queued and checked by a monitor.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        tb;
  } ifid_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallD, FlushD, RedirectE;
  logic [31:0] RedirectPCE;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemValid;
  logic [31:0] ImemData;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        TakingBranch, FetchBusy;

  int checks = 0;
  int errors = 0;
  int n_deliv = 0;

  ifid_t       q[$];
  ifid_t       exp_ifid;
  logic [31:0] mpc;
  int          lat_cfg;

  logic        req_n, red_n;
  logic [31:0] addr_n;
  bit          busy;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .RedirectE(RedirectE), .RedirectPCE(RedirectPCE),
    .ImemReq(ImemReq), .ImemAddr(ImemAddr),
    .ImemValid(ImemValid), .ImemData(ImemData),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .TakingBranch(TakingBranch), .FetchBusy(FetchBusy)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_b(int imm);
    logic [31:0] v;
    logic [12:0] i;
    v = imm;
    i = v[12:0];
    return {i[12], i[10:5], 5'd0, 5'd0, 3'b000, i[4:1], i[11], 7'h63};
  endfunction

  // Program image: a short directed program plus hashed filler
  function automatic logic [31:0] mem_word(logic [31:0] a);
    logic [31:0] h;
    if (a == 32'h10) return 32'hFE000EE3;
    if (a == 32'h100) return 32'h00000463;
    if (a == 32'hFFFFFFFC) return 32'h00100093;
    if (a < 32'h10) return 32'h00000093 | (a << 20);
    h = a * 32'h9E3779B1;
    h = h ^ (h >> 15);
    if (h[3:0] == 4'd0) return enc_b(-4 * (int'(h[7:4]) + 1));
    if (h[2:0] == 3'd1) return enc_b(4 * (int'(h[7:4]) + 1));
    return {h[31:7], 7'h13};
  endfunction

  function automatic bit is_taken(logic [31:0] w);
    return (w[6:0] == 7'h63) && w[31];
  endfunction

  function automatic logic [31:0] model_next(logic [31:0] pc);
    logic [31:0] w;
    int off;
    w = mem_word(pc);
    if (!is_taken(w)) return pc + 32'd4;
    off = -4096 + 2048 * int'(w[7]) + 32 * int'(w[30:25])
          + 2 * int'(w[11:8]);
    return pc + off;
  endfunction

  function automatic ifid_t model_item(logic [31:0] pc);
    ifid_t it;
    it.pc    = pc;
    it.instr = mem_word(pc);
    it.pc4   = pc + 32'd4;
    it.tb    = is_taken(it.instr);
    return it;
  endfunction

  task automatic refill();
    while (q.size() < 1) begin
      q.push_back(model_item(mpc));
      mpc = model_next(mpc);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      refill();
    end
  endtask

  task automatic redirect_to(logic [31:0] t);
    RedirectE   = 1'b1;
    FlushD      = 1'b1;
    RedirectPCE = t;
    q.delete();
    mpc = t;
    refill();
    @(posedge clk);
    #2;
    RedirectE = 1'b0;
    FlushD    = 1'b0;
    refill();
  endtask

  // Sample DUT request side before each active edge
  always @(negedge clk) begin
    req_n  = ImemReq;
    addr_n = ImemAddr;
    red_n  = RedirectE;
  end

  // Instruction memory responder with configurable latency
  initial begin
    int cnt;
    int lat;
    bit redir_seen;
    logic [31:0] req_addr;
    ImemValid = 1'b0;
    ImemData  = '0;
    busy      = 1'b0;
    cnt       = 0;
    redir_seen = 1'b0;
    req_addr  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        busy      = 1'b0;
        ImemValid = 1'b0;
      end else if (ImemValid) begin
        ImemValid = 1'b0;
        busy      = 1'b0;
      end else if (busy) begin
        redir_seen = redir_seen | red_n;
        if (!redir_seen && ImemReq)
          chk("imem_addr_stable", ImemAddr, req_addr);
        cnt--;
        if (cnt <= 0) begin
          ImemValid = 1'b1;
          ImemData  = mem_word(req_addr);
        end
      end else if (req_n) begin
        busy       = 1'b1;
        req_addr   = addr_n;
        redir_seen = red_n;
        lat = (lat_cfg == 0) ? int'($urandom_range(1, 4)) : lat_cfg;
        cnt = lat - 1;
        if (cnt <= 0) begin
          ImemValid = 1'b1;
          ImemData  = mem_word(req_addr);
        end
      end
    end
  end

  // Monitor: predict IF/ID update per edge, compare after the edge
  initial begin
    ifid_t nxt;
    ifid_t bub;
    bub.pc    = '0;
    bub.instr = NOP;
    bub.pc4   = '0;
    bub.tb    = 1'b0;
    exp_ifid  = bub;
    forever begin
      @(negedge clk);
      if (!rst) nxt = bub;
      else if (FlushD) nxt = bub;
      else if (StallD) nxt = exp_ifid;
      else if (!FetchBusy) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: got delivery expected none");
          nxt = bub;
        end else begin
          nxt = q.pop_front();
          n_deliv++;
        end
      end else nxt = bub;
      @(posedge clk);
      #1;
      exp_ifid = nxt;
      chk("PCD", PCD, exp_ifid.pc);
      chk("InstrD", InstrD, exp_ifid.instr);
      chk("PCPlus4D", PCPlus4D, exp_ifid.pc4);
      chk("TakingBranch", 32'(TakingBranch), 32'(exp_ifid.tb));
    end
  end

  // Stimulus
  initial begin
    int n;
    logic [31:0] t;
    rst = 1'b0;
    StallF = 0; StallD = 0; FlushD = 0; RedirectE = 0;
    RedirectPCE = '0;
    lat_cfg = 1;
    mpc = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_InstrD", InstrD, NOP);
    chk("rst_PCD", PCD, 32'h0);
    chk("rst_PCPlus4D", PCPlus4D, 32'h0);
    chk("rst_TakingBranch", 32'(TakingBranch), 32'h0);
    chk("rst_FetchBusy", 32'(FetchBusy), 32'h1);
    chk("rst_ImemReq", 32'(ImemReq), 32'h0);
    chk("rst_ImemAddr", ImemAddr, 32'h0);
    refill();
    rst = 1'b1;
    #1;
    chk("idle_ImemReq", 32'(ImemReq), 32'h0);
    step(1);
    chk("first_ImemReq", 32'(ImemReq), 32'h1);
    chk("first_ImemAddr", ImemAddr, 32'h0);
    step(40);

    lat_cfg = 3;
    step(30);

    lat_cfg = 2;
    n = 0;
    while (!ImemValid && n < 20) begin
      step(1);
      n++;
    end
    chk("hold_wait_valid", 32'(ImemValid), 32'h1);
    StallF = 1'b1;
    StallD = 1'b1;
    step(1);
    chk("hold_ImemReq", 32'(ImemReq), 32'h0);
    chk("hold_FetchBusy", 32'(FetchBusy), 32'h1);
    step(2);
    chk("hold2_ImemReq", 32'(ImemReq), 32'h0);
    StallF = 1'b0;
    StallD = 1'b0;
    #1;
    chk("hold_release_busy", 32'(FetchBusy), 32'h0);
    step(1);
    chk("hold_rel_ImemReq", 32'(ImemReq), 32'h1);
    step(10);

    lat_cfg = 3;
    n = 0;
    while (!(busy && !ImemValid) && n < 20) begin
      step(1);
      n++;
    end
    chk("redir_wait_busy", 32'(busy), 32'h1);
    redirect_to(32'h100);
    step(25);

    lat_cfg = 1;
    redirect_to(32'hFFFFFFFC);
    step(25);

    lat_cfg = 0;
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin
        StallF = 0; StallD = 0; RedirectE = 0; FlushD = 0;
        rst = 1'b0;
        q.delete();
        mpc = 32'h0;
        @(posedge clk);
        #2;
        chk("midrst_FetchBusy", 32'(FetchBusy), 32'h1);
        chk("midrst_ImemReq", 32'(ImemReq), 32'h0);
        chk("midrst_ImemAddr", ImemAddr, 32'h0);
        refill();
        rst = 1'b1;
      end
      StallF = ($urandom_range(0, 4) == 0);
      StallD = ($urandom_range(0, 5) == 0);
      if (ImemValid && $urandom_range(0, 2) == 0) begin
        StallF = 1'b1;
        StallD = 1'b1;
      end
      RedirectE = ($urandom_range(0, 49) == 0);
      FlushD = RedirectE;
      if (RedirectE) begin
        case ($urandom_range(0, 3))
          0: t = 32'h100;
          1: t = 32'hFFFFFFFC;
          2: t = 32'h10;
          default: t = $urandom & 32'hFFFFFFFC;
        endcase
        RedirectPCE = t;
        q.delete();
        mpc = t;
      end
      refill();
      @(posedge clk);
      #2;
    end
    StallF = 0; StallD = 0; RedirectE = 0; FlushD = 0;
    step(10);
    checks++;
    if (n_deliv < 100) begin
      errors++;
      $display("FAIL deliveries: got %0d expected at least 100", n_deliv);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
